// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg
//   Shared definitions for the system-clock-side debug command dispatcher:
//   debug channel numbers (the index of a take_action / take_no_action bit),
//   the command entry layout for the default 2-bit IR / 38-bit DR
//   configuration, and the helper that sizes the FIFO occupancy counter.
package debug_cmd_pkg;

    // Debug channels, selected by the IR value of a command.
    localparam int CH_OCIMEM    = 0;
    localparam int CH_TRACEMEM  = 1;
    localparam int CH_BREAK     = 2;
    localparam int CH_TRACECTRL = 3;

    localparam int DEF_IR_W = 2;
    localparam int DEF_DR_W = 38;

    // Command entry for the default configuration. The dispatcher declares
    // an equivalent entry sized by its own IR_W / DR_W parameters.
    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_DR_W-1:0] sr;
    } cmd_entry_t;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/debug_cmd_dispatch_sync_rise_det.sv
// sync_rise_det
//   Brings an asynchronous level strobe into the clk domain and emits a
//   registered one-cycle pulse for every rising edge. The detector stays
//   disarmed after reset until the strobe has been seen low. A strobe that is
//   held high across reset release therefore produces no event.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   async_in in   level strobe, asynchronous to clk
//   rise     out  one-cycle pulse, registered
module sync_rise_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Marks which synchroniser stages hold a real sample rather than a reset
    // value. Without it, the zeros left in the chain by reset would look like
    // "strobe seen low" and arm the detector too early.
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic                   rise_q, rise_d;
    logic                   sync_out;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
        fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;
        armed_d  = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
        rise_d   = sync_out & ~prev_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/debug_cmd_dispatch.sv
// debug_cmd_dispatch
//   System-clock-side command dispatcher for the CPU debug slave. Update-DR
//   strobes from the JTAG-clock logic are synchronised, and each one queues
//   {ir_in, sr} into a command FIFO. Popping the head under cmd_valid /
//   cmd_ready drives jdo with the shift data. The pop also raises a one-cycle
//   take_action or take_no_action pulse on the channel named by the IR.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   ir_in, sr          instruction / shift data, quasi-static around vs_udr
//   vs_udr, vs_uir     update-DR / update-IR levels, asynchronous to clk
//   cmd_ready          consumer accepts the head command
//   clr_overflow       clears the sticky overflow flag
//   cmd_valid, cmd_ir  FIFO non-empty, IR of the head entry
//   jdo                sr of the last popped entry (held)
//   take_action        one-hot pulse, popped sr[ACT_BIT] = 1
//   take_no_action     one-hot pulse, popped sr[ACT_BIT] = 0
//   ir_update          one-cycle pulse per update-IR
//   overflow           sticky: a push was dropped on a full FIFO
//   fifo_level         current FIFO occupancy
module debug_cmd_dispatch
    import debug_cmd_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACT_BIT     = 37,   // must be < DR_W
    parameter int SYNC_STAGES = 2,    // must be >= 2
    parameter int FIFO_DEPTH  = 4     // power of two, >= 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [IR_W-1:0]                  ir_in,
    input  logic [DR_W-1:0]                  sr,
    input  logic                             vs_udr,
    input  logic                             vs_uir,
    input  logic                             cmd_ready,
    input  logic                             clr_overflow,
    output logic                             cmd_valid,
    output logic [IR_W-1:0]                  cmd_ir,
    output logic [DR_W-1:0]                  jdo,
    output logic [2**IR_W-1:0]               take_action,
    output logic [2**IR_W-1:0]               take_no_action,
    output logic                             ir_update,
    output logic                             overflow,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level
);

    localparam int NCH   = 2**IR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = level_w(FIFO_DEPTH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] sr;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [DR_W-1:0]    jdo_q, jdo_d;
    logic [NCH-1:0]     take_action_q, take_action_d;
    logic [NCH-1:0]     take_no_action_q, take_no_action_d;
    logic               ir_update_q, ir_update_d;

    logic               udr_rise;
    logic               uir_rise;
    entry_t             head;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_udr_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_uir_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    always_comb begin
        head  = mem_q[rd_ptr_q];
        empty = (level_q == '0);
        full  = (level_q == LVL_W'(FIFO_DEPTH));
        pop   = ~empty & cmd_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = udr_rise & (~full | pop);
        drop    = udr_rise & full & ~pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{ir: ir_in, sr: sr};
        end

        // Depth is a power of two, so the pointers wrap on their own.
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new drop wins over a clear in the same cycle.
        overflow_d = drop | (overflow_q & ~clr_overflow);

        jdo_d            = pop ? head.sr : jdo_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            if (head.sr[ACT_BIT]) begin
                take_action_d[head.ir] = 1'b1;
            end else begin
                take_no_action_d[head.ir] = 1'b1;
            end
        end

        // Extra register so the pulse appears in the same cycle that a push
        // from the matching update-DR would first show up as cmd_valid.
        ir_update_d = uir_rise;
    end

    // Queue storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            overflow_q       <= 1'b0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            ir_update_q      <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            overflow_q       <= overflow_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            ir_update_q      <= ir_update_d;
        end
    end

    assign cmd_valid      = ~empty;
    assign cmd_ir         = empty ? '0 : head.ir;
    assign jdo            = jdo_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_update      = ir_update_q;
    assign overflow       = overflow_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// tb_debug_cmd_dispatch
//   Directed-vector bench for debug_cmd_dispatch with default parameters.
//   Inputs change on the falling clock edge and outputs are sampled there too.
module tb_debug_cmd_dispatch;
    import debug_cmd_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        cmd_ready;
    logic        clr_overflow;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic        overflow;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_cmd_dispatch dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_ready      (cmd_ready),
        .clr_overflow   (clr_overflow),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One update-DR strobe, followed by enough low time to re-arm the detector.
    task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] data, input int n_high);
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        repeat (n_high) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        ir_in        = '0;
        sr           = '0;
        vs_udr       = 1'b0;
        vs_uir       = 1'b0;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_valid",  64'(cmd_valid), 64'd0);
        check_val("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        check_val("rst_jdo",    64'(jdo), 64'd0);
        check_val("rst_ta",     64'(take_action), 64'd0);
        check_val("rst_tna",    64'(take_no_action), 64'd0);
        check_val("rst_irupd",  64'(ir_update), 64'd0);
        check_val("rst_ovf",    64'(overflow), 64'd0);
        check_val("rst_level",  64'(fifo_level), 64'd0);
        repeat (4) @(negedge clk);

        // Latency: the pulse follows edge 0 by SYNC_STAGES+2 edges
        ir_in     = 2'(CH_BREAK);
        sr        = 38'h20_0000_1234;
        cmd_ready = 1'b1;
        vs_udr    = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val($sformatf("lat_ta_k%0d", k), 64'(take_action),
                      (k == SYNC_STAGES + 2) ? 64'h4 : 64'h0);
            if (k == SYNC_STAGES + 1) begin
                check_val("lat_valid", 64'(cmd_valid), 64'd1);
                check_val("lat_cmd_ir", 64'(cmd_ir), 64'd2);
            end
            if (k >= SYNC_STAGES + 2) begin
                check_val($sformatf("lat_jdo_k%0d", k), 64'(jdo), 64'h20_0000_1234);
                check_val($sformatf("lat_tna_k%0d", k), 64'(take_no_action), 64'd0);
            end
        end
        repeat (3) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);

        // No-action path
        ir_in  = 2'(CH_OCIMEM);
        sr     = 38'h0_0000_00AB;
        vs_udr = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k == SYNC_STAGES + 2) begin
                check_val("na_tna", 64'(take_no_action), 64'h1);
                check_val("na_ta",  64'(take_action), 64'h0);
                check_val("na_jdo", 64'(jdo), 64'hAB);
            end
        end
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);

        // Overflow: five pushes into a four-entry queue
        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) udr_pulse(2'd0, 38'(i), 2);
        check_val("ovf_level", 64'(fifo_level), 64'd4);
        check_val("ovf_flag",  64'(overflow), 64'd1);
        check_val("ovf_valid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val($sformatf("ovf_pop_jdo%0d", i), 64'(jdo), 64'(i));
            check_val($sformatf("ovf_pop_tna%0d", i), 64'(take_no_action), 64'h1);
        end
        cmd_ready = 1'b0;
        check_val("ovf_drained", 64'(fifo_level), 64'd0);
        check_val("ovf_empty_valid", 64'(cmd_valid), 64'd0);
        check_val("ovf_still_set", 64'(overflow), 64'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check_val("ovf_cleared", 64'(overflow), 64'd0);

        // Push and pop in the same cycle while full
        for (int i = 11; i <= 14; i++) udr_pulse(2'd0, 38'(i), 2);
        check_val("pp_full", 64'(fifo_level), 64'd4);
        ir_in  = 2'd0;
        sr     = 38'd15;
        vs_udr = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check_val("pp_level", 64'(fifo_level), 64'd4);
        check_val("pp_ovf",   64'(overflow), 64'd0);
        check_val("pp_jdo",   64'(jdo), 64'd11);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
        cmd_ready = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            tick();
            check_val($sformatf("pp_drain_jdo%0d", i), 64'(jdo), 64'(i));
        end
        cmd_ready = 1'b0;
        check_val("pp_drained", 64'(fifo_level), 64'd0);

        // Reset arming: strobe held high across reset release
        reset  = 1'b1;
        vs_udr = 1'b1;
        ir_in  = 2'd1;
        sr     = 38'h3F;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_val("arm_level", 64'(fifo_level), 64'd0);
        check_val("arm_valid", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        udr_pulse(2'd1, 38'h3F, 5);
        check_val("arm_one_push", 64'(fifo_level), 64'd1);
        check_val("arm_cmd_ir",   64'(cmd_ir), 64'd1);

        // ir_update pulse leaves the queue alone
        vs_uir = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            check_val($sformatf("iru_k%0d", k), 64'(ir_update),
                      (k == SYNC_STAGES + 1) ? 64'd1 : 64'd0);
        end
        vs_uir = 1'b0;
        repeat (4) @(negedge clk);
        check_val("iru_level", 64'(fifo_level), 64'd1);

        // Reset mid-operation, with a pop pulse in flight
        udr_pulse(2'd3, 38'h20_0000_0001, 2);
        udr_pulse(2'd2, 38'h0_0000_0002, 2);
        check_val("mid_level", 64'(fifo_level), 64'd3);
        cmd_ready = 1'b1;
        tick();
        check_val("mid_pop_tna", 64'(take_no_action), 64'h2);
        reset     = 1'b1;
        cmd_ready = 1'b0;
        tick();
        check_val("mid_level0", 64'(fifo_level), 64'd0);
        check_val("mid_valid0", 64'(cmd_valid), 64'd0);
        check_val("mid_ta0",    64'(take_action), 64'd0);
        check_val("mid_tna0",   64'(take_no_action), 64'd0);
        check_val("mid_jdo0",   64'(jdo), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_cmd_dispatch.md
Name: debug_cmd_dispatch

Overview:
- Parametrised system-clock-side command dispatcher for the CPU debug slave; successor to the fixed 2-bit-IR, 38-bit-DR sysclk decoder.
- Receives update-DR and update-IR strobes from the JTAG-clock logic, synchronises them and captures {ir_in, sr} into a command FIFO.
- Under a valid/ready handshake, emits registered per-channel take_action / take_no_action pulses with the shift data on jdo.
- Adds generalised IR/DR width, queuing of back-to-back scans, overflow detection and reset-safe edge arming.

Parameters:
- IR_W, 2, instruction width; channel count NCH = 2**IR_W.
- DR_W, 38, shift-register / jdo width.
- ACT_BIT, 37, index into sr selecting action vs no-action; must be < DR_W.
- SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir; must be >= 2.
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ir_in  in  IR_W  instruction from the JTAG-clock side; quasi-static around vs_udr.
- sr  in  DR_W  shift-register contents; quasi-static around vs_udr.
- vs_udr  in  1  update-DR level, asynchronous to clk.
- vs_uir  in  1  update-IR level, asynchronous to clk.
- cmd_ready  in  1  consumer accepts the head command.
- clr_overflow  in  1  clears the sticky overflow flag.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ir  out  IR_W  IR of the head entry (combinational from FIFO).
- jdo  out  DR_W  sr of the last popped entry (registered).
- take_action  out  NCH  one-hot pulse on pop with sr[ACT_BIT]=1.
- take_no_action  out  NCH  one-hot pulse on pop with sr[ACT_BIT]=0.
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rise.
- overflow  out  1  sticky: a push was dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, active-high): all outputs 0. FIFO emptied. Synchroniser flops 0. Edge detectors disarmed.
- Edge detect: each strobe passes through SYNC_STAGES flops, then a registered previous-value flop.
  - rise = sync_out & ~prev & armed.
  - armed sets on the first clk where sync_out==0 after reset, and stays set until the next reset.
  - A strobe held high across reset release therefore produces no event until it has been seen low.
- Latency: let edge 0 be the clk edge that first samples vs_udr=1. The push occurs at edge SYNC_STAGES+1, so cmd_valid is high after that edge.
  - There is no empty-FIFO bypass.
- Push: on a vs_udr rise, {ir_in, sr} is written as sampled at the push edge.
- Full FIFO:
  - A push when full with no pop in the same cycle is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen, no overflow.
- Pop: occurs when cmd_valid & cmd_ready. At the same edge:
  - jdo <= head.sr.
  - take_action[head.ir] <= head.sr[ACT_BIT], or take_no_action[head.ir] <= ~head.sr[ACT_BIT]. All other bits are 0.
  - The pulse and the new jdo are visible in the cycle after the pop, for exactly one cycle.
  - jdo holds its value until the next pop.
- Throughput: one pop per cycle maximum, so back-to-back pops give consecutive pulses.
- Empty FIFO: cmd_valid=0 and cmd_ir=0; cmd_ready is ignored.
- ir_update: one-cycle pulse at the same relative latency as a push. It does not touch FIFO contents.
- overflow: if clr_overflow and a new drop occur in the same cycle, set wins.
- fifo_level: updated each edge as +push −pop; unchanged when push and pop coincide.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: queued entries are discarded. Pulses in flight are cancelled, so outputs are 0 after the reset edge.

Decomposition:
- Package debug_cmd_pkg holds:
  - channel constants CH_OCIMEM=0, CH_TRACEMEM=1, CH_BREAK=2, CH_TRACECTRL=3;
  - the FIFO entry struct {ir, sr};
  - a clog2-derived level width helper.
- Sub-module sync_rise_det (synchroniser + armed rise detect, parameter SYNC_STAGES) is instantiated twice.
- FIFO and output decode are inline.

Test Plan:
- Latency: defaults, cmd_ready=1, ir_in=2, sr=38'h20_0000_1234, pulse vs_udr high 10 cycles → take_action=4'b0100 for exactly 1 cycle, SYNC_STAGES+2 cycles after edge 0; jdo=38'h20_0000_1234 from that cycle onward.
- No-action path: ir_in=0, sr[37]=0, sr=38'h0_0000_00AB → take_no_action=4'b0001, take_action=0, jdo=38'h0_0000_00AB.
- Overflow: cmd_ready=0, 5 udr pulses with sr=1..5 → fifo_level=4, overflow=1; then cmd_ready=1 → four pops with jdo 1,2,3,4 on consecutive cycles; clr_overflow → overflow=0.
- Push and pop while full: level 4, cmd_ready=1, push coincides with pop → fifo_level stays 4, overflow stays 0.
- Reset arming: vs_udr held high through reset release for 20 cycles → no push, fifo_level=0; then low 3 cycles and high again → exactly one push.
- ir_update and mid-op reset: vs_uir pulse → ir_update 1 cycle, FIFO unchanged; with 3 entries queued, assert reset 1 cycle → fifo_level=0, cmd_valid=0, all pulses 0.
